// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-word memory port among NUM_CORES cores.
// Latency: request sampled at edge N drives mem_req after N; ack one edge after mem_ack; 1-cycle DONE gap.
// Backpressure: cores hold core_req until core_ack; BUSY waits on mem_ack (ARB_TIMEOUT_EN adds an abort).
module mem_arbiter #(
    parameter int NUM_CORES      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            core_req,
    input  logic [NUM_CORES-1:0]            core_we,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] core_wdata,
    output logic [NUM_CORES-1:0]            core_ack,
    output logic [NUM_CORES-1:0]            core_err,
    output logic [DATA_WIDTH-1:0]           core_rdata,
    output logic [NUM_CORES-1:0]            core_gnt,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_ack,
    output logic                            busy
);

    localparam int PW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PW1 = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic [PW-1:0]         ptr_q,       ptr_d;
    logic [PW-1:0]         gidx_q,      gidx_d;
    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [NUM_CORES-1:0]  gnt_q,       gnt_d;
    logic [NUM_CORES-1:0]  ack_q,       ack_d;
    logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;

    logic [NUM_CORES-1:0]  req_rot;
    logic [PW1-1:0]        win_off;
    logic [PW1-1:0]        win_sum;
    logic [PW-1:0]         win_idx;
    logic                  win_vld;

    // Rotate requests so bit 0 is the core at ptr; the lowest set bit is the winner's offset.
    always_comb begin
        req_rot = NUM_CORES'({core_req, core_req} >> ptr_q);
        win_off = '0;
        win_vld = 1'b0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = PW1'(k);
                win_vld = 1'b1;
            end
        end
        win_sum = {1'b0, ptr_q} + win_off;
        if (win_sum >= PW1'(NUM_CORES)) begin
            win_sum = win_sum - PW1'(NUM_CORES);
        end
        win_idx = win_sum[PW-1:0];
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic [NUM_CORES-1:0]  err_q,    err_d;
    logic                  to_hit;

    assign to_hit   = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign core_err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES[0];
    assign core_err       = '0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
`ifdef ARB_TIMEOUT_EN
        err_d       = '0;
        to_cnt_d    = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    gidx_d      = win_idx;
                    gnt_d       = NUM_CORES'(1) << win_idx;
                    mem_req_d   = 1'b1;
                    mem_we_d    = core_we[win_idx];
                    mem_addr_d  = core_addr[win_idx * ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d = core_wdata[win_idx * DATA_WIDTH +: DATA_WIDTH];
                    state_d     = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
                    to_cnt_d    = '0;
`endif
                end
            end
            ST_BUSY: begin
                // mem_ack wins over a coincident timeout.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    rdata_d   = mem_rdata;
                    ack_d     = NUM_CORES'(1) << gidx_q;
                    state_d   = ST_DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_hit) begin
                    mem_req_d = 1'b0;
                    rdata_d   = DATA_WIDTH'(32'hDEAD_BEEF);
                    ack_d     = NUM_CORES'(1) << gidx_q;
                    err_d     = NUM_CORES'(1) << gidx_q;
                    state_d   = ST_DONE;
                end else begin
                    to_cnt_d  = to_cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                ptr_d   = (gidx_q == PW'(NUM_CORES - 1)) ? '0 : gidx_q + 1'b1;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            err_q       <= '0;
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
`ifdef ARB_TIMEOUT_EN
            err_q       <= err_d;
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign core_ack   = ack_q;
    assign core_rdata = rdata_q;
    assign core_gnt   = gnt_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one data-memory port between the NUM_CORES cores of the processor.
- Each core issues single-word read/write requests over a hold-until-ack handshake.
- The arbiter serialises the requests onto one memory-side request/acknowledge port and routes the response back to the granted core.
- It sits between the core data ports and the shared memory in the multi-core top level.

Parameters:
- NUM_CORES, 2, number of requesting cores (legal range 1..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data word width.
- TIMEOUT_CYCLES, 255, BUSY cycles before abort (used only with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- core_req  input  NUM_CORES  per-core request, held until the matching core_ack.
- core_we  input  NUM_CORES  per-core write enable (1 = write, 0 = read).
- core_addr  input  NUM_CORES*ADDR_WIDTH  flattened addresses; core i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- core_wdata  input  NUM_CORES*DATA_WIDTH  flattened write data, sliced the same way.
- core_ack  output  NUM_CORES  one-hot, one-cycle completion pulse.
- core_err  output  NUM_CORES  one-hot error pulse, coincident with core_ack.
- core_rdata  output  DATA_WIDTH  read data, shared by all cores, valid when core_ack is high.
- core_gnt  output  NUM_CORES  one-hot current owner.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_ack.
- mem_ack  input  1  memory completion, single-cycle pulse.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; priority pointer ptr = 0.
- Reset asserted mid-transaction abandons it immediately. No ack is issued for the abandoned transaction.
- FSM IDLE:
  - If core_req != 0, select the first requesting index scanning ptr, ptr+1, ..., wrapping modulo NUM_CORES.
  - Register the winner's we, addr and wdata into mem_we, mem_addr and mem_wdata.
  - Set core_gnt, set mem_req = 1, and go to BUSY.
  - Latency: core_req sampled high at edge N gives mem_req high after edge N.
- FSM BUSY:
  - mem_req and the mem_* outputs stay stable.
  - On the edge where mem_ack = 1: clear mem_req, capture core_rdata <= mem_rdata (writes capture it too), pulse core_ack[g] for one cycle, go to DONE.
- FSM DONE:
  - core_ack returns to 0.
  - ptr <= (g+1) mod NUM_CORES.
  - core_gnt <= 0; go to IDLE.
  - This one-cycle gap lets the requester drop core_req, so the same request is never granted twice.
- Grant to completion takes a minimum of 3 cycles (IDLE to BUSY to DONE) when mem_ack arrives on the first BUSY cycle.
- Simultaneous requests: the lowest index at or after ptr wins; the others wait. Starvation-free, with at most NUM_CORES-1 intervening grants.
- core_req dropped during BUSY: the transaction still completes and the ack is still pulsed (committed).
- core_req, addr or data changing during BUSY has no effect; the values are latched.
- mem_ack outside BUSY is ignored.
- core_rdata holds its value until the next completion.
- ptr width is max(1, ceil(log2(NUM_CORES))); increment wraps explicitly at NUM_CORES (not power-of-two overflow).
- NUM_CORES = 1: ptr stays 0; core 0 is always granted.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - An 8+ bit counter clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES: clear mem_req, pulse core_ack[g] and core_err[g] together, set core_rdata = 32'hDEADBEEF (truncated to DATA_WIDTH), go to DONE.
  - A mem_ack arriving on the same edge as the timeout takes priority: normal completion, no error.
- Disabled: BUSY waits indefinitely; core_err is tied to 0.

Test Plan:
- Single read: core0 req, we=0, addr=0x40; mem_ack one cycle later with mem_rdata=0x1234 -> mem_addr=0x40 and mem_we=0; core_ack=2'b01 for one cycle; core_rdata=0x1234; busy low again 3 cycles after the grant.
- Contention: both cores request the same cycle, ptr=0 -> core0 served first, then core1. A second simultaneous burst after that -> core0 first again (ptr wrapped to 0 after serving core1).
- Repeated requester: core1 holds req continuously while core0 also requests -> grants alternate 0,1,0,1; no core is granted twice in a row while the other waits.
- Write passthrough: core1 we=1, addr=0x80, wdata=0xCAFEF00D; inputs changed during BUSY -> mem_wdata stays 0xCAFEF00D, mem_addr stays 0x80 until mem_ack.
- Reset mid-BUSY: assert reset with mem_req=1 -> all outputs 0 immediately (asynchronous); no core_ack pulse; after release the pending core_req is re-granted from ptr=0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): no mem_ack -> mem_req drops after 4 BUSY cycles; core_ack and core_err pulse together; core_rdata=0xDEADBEEF.
